// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared types and config helpers for the BE-to-FE command path
package bp_be_pkg;

  // Processor configurations; only the default one exists today
  typedef enum logic [0:0] {
    e_bp_default_cfg
  } bp_params_e;

  localparam int bp_vaddr_width_gp = 39;

  // FE branch metadata forwarded through the BE untouched (is_br is the LSB)
  typedef struct packed {
    logic [3:0] bht_idx;
    logic       src_btb;
    logic       is_jalr;
    logic       is_jal;
    logic       is_br;
  } bp_fe_branch_metadata_fwd_s;

  localparam int bp_md_width_gp = $bits(bp_fe_branch_metadata_fwd_s);

  typedef enum logic [0:0] {
    e_run,
    e_wait
  } bp_be_fe_cmd_state_e;

  // One queued attaboy: training target, metadata and direction qualifiers
  typedef struct packed {
    logic [bp_vaddr_width_gp-1:0] pc;
    bp_fe_branch_metadata_fwd_s   md;
    logic                         taken;
    logic                         ntaken;
  } bp_be_attaboy_entry_s;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_vaddr_width_gp;
      default:          return bp_vaddr_width_gp;
    endcase
  endfunction

  function automatic int bp_md_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_md_width_gp;
      default:          return bp_md_width_gp;
    endcase
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small circular-buffer FIFO with registered outputs
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] mem_d [els_p];
  logic [ptr_w-1:0]   rptr_q, rptr_d;
  logic [ptr_w-1:0]   wptr_q, wptr_d;
  logic [cnt_w-1:0]   count_q, count_d;
  logic               enq, deq;

  assign v_o    = (count_q != '0);
  assign data_o = mem_q[rptr_q];
  assign deq    = yumi_i & v_o;
  // A dequeue frees its slot in the same cycle, so a full queue can still accept
  assign ready_o = (count_q != cnt_w'(els_p)) | deq;
  assign enq     = v_i & ready_o;

  // Pointer, occupancy and storage next-state
  always_comb begin
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (enq) begin
      mem_d[wptr_q] = data_i;
      wptr_d = (wptr_q == ptr_w'(els_p - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (deq) begin
      rptr_d = (rptr_q == ptr_w'(els_p - 1)) ? '0 : rptr_q + 1'b1;
    end
    if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (deq && !enq) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state resets; storage contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bp_be_fe_cmd_gen.sv
// rtl/bp_be_fe_cmd_gen.sv - turns resolved control flow into FE redirects and attaboys
module bp_be_fe_cmd_gen
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p   = e_bp_default_cfg,
  parameter int         attaboy_els_p = 4,
  parameter int         cnt_width_p   = 16,
  localparam int        vaddr_width_p = bp_vaddr_width(bp_params_p),
  localparam int        branch_metadata_fwd_width_p = bp_md_width(bp_params_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,

  input  logic                                   resolve_v_i,
  output logic                                   resolve_ready_o,
  input  logic                                   resolve_epoch_i,
  input  logic [vaddr_width_p-1:0]               resolve_pc_i,
  input  logic [vaddr_width_p-1:0]               resolve_npc_i,
  input  logic [vaddr_width_p-1:0]               resolve_pred_npc_i,
  input  logic                                   resolve_taken_i,
  input  logic [branch_metadata_fwd_width_p-1:0] resolve_br_metadata_fwd_i,

  output logic                                   redirect_v_o,
  input  logic                                   redirect_yumi_i,
  output logic [vaddr_width_p-1:0]               redirect_pc_o,
  output logic                                   redirect_br_v_o,
  output logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o,
  output logic                                   redirect_br_taken_o,
  output logic                                   redirect_br_ntaken_o,
  output logic                                   redirect_br_nonbr_o,

  output logic                                   attaboy_v_o,
  input  logic                                   attaboy_yumi_i,
  output logic [vaddr_width_p-1:0]               attaboy_pc_o,
  output logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o,
  output logic                                   attaboy_taken_o,
  output logic                                   attaboy_ntaken_o,

  output logic                                   epoch_o,
  output logic [cnt_width_p-1:0]                 mispredict_cnt_o,
  output logic [cnt_width_p-1:0]                 attaboy_cnt_o
);

  bp_be_fe_cmd_state_e state_q, state_d;
  logic                                   epoch_q, epoch_d;
  logic [vaddr_width_p-1:0]               redirect_pc_q, redirect_pc_d;
  logic                                   redirect_br_v_q, redirect_br_v_d;
  logic [branch_metadata_fwd_width_p-1:0] redirect_md_q, redirect_md_d;
  logic                                   redirect_taken_q, redirect_taken_d;
  logic                                   redirect_ntaken_q, redirect_ntaken_d;
  logic                                   redirect_nonbr_q, redirect_nonbr_d;
  logic [cnt_width_p-1:0]                 mis_cnt_q, mis_cnt_d;
  logic [cnt_width_p-1:0]                 att_cnt_q, att_cnt_d;

  bp_fe_branch_metadata_fwd_s resolve_md;
  bp_be_attaboy_entry_s       fifo_data_in, fifo_data_out;
  logic fifo_ready, fifo_v, fifo_enq, fifo_deq;
  logic accept, same_epoch, cf, mispredict, load_redirect;
  logic unused_resolve_pc;

  // The instruction PC is not needed to classify; only the next-PC pair matters
  assign unused_resolve_pc = ^resolve_pc_i;

  assign resolve_md      = bp_fe_branch_metadata_fwd_s'(resolve_br_metadata_fwd_i);
  assign resolve_ready_o = (state_q == e_run) & fifo_ready;
  assign accept          = resolve_v_i & resolve_ready_o;
  assign same_epoch      = (resolve_epoch_i == epoch_q);
  assign cf              = resolve_md.is_br | resolve_md.is_jal | resolve_md.is_jalr;
  assign mispredict      = (resolve_npc_i != resolve_pred_npc_i);
  assign load_redirect   = accept & same_epoch & mispredict;
  assign fifo_enq        = accept & same_epoch & ~mispredict & cf;

  assign attaboy_v_o = fifo_v & (state_q == e_run);
  assign fifo_deq    = attaboy_yumi_i & attaboy_v_o;

  assign fifo_data_in.pc     = resolve_npc_i;
  assign fifo_data_in.md     = resolve_md;
  assign fifo_data_in.taken  = resolve_taken_i;
  assign fifo_data_in.ntaken = ~resolve_taken_i;

  bsg_fifo_1r1w_small #(
    .width_p ($bits(bp_be_attaboy_entry_s)),
    .els_p   (attaboy_els_p)
  ) attaboy_fifo (
    .clk_i   (clk_i),
    .reset_i (~reset_n_i),
    .v_i     (fifo_enq),
    .ready_o (fifo_ready),
    .data_i  (fifo_data_in),
    .v_o     (fifo_v),
    .data_o  (fifo_data_out),
    .yumi_i  (fifo_deq)
  );

  // Run until a redirect is loaded, then hold it until the FE consumes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_run:   if (load_redirect)   state_d = e_wait;
      e_wait:  if (redirect_yumi_i) state_d = e_run;
      default: state_d = e_run;
    endcase
  end

  // Redirect capture, epoch flip and saturating statistics
  always_comb begin
    epoch_d           = epoch_q;
    redirect_pc_d     = redirect_pc_q;
    redirect_br_v_d   = redirect_br_v_q;
    redirect_md_d     = redirect_md_q;
    redirect_taken_d  = redirect_taken_q;
    redirect_ntaken_d = redirect_ntaken_q;
    redirect_nonbr_d  = redirect_nonbr_q;
    mis_cnt_d         = mis_cnt_q;
    att_cnt_d         = att_cnt_q;
    if (load_redirect) begin
      epoch_d           = ~epoch_q;
      redirect_pc_d     = resolve_npc_i;
      redirect_br_v_d   = 1'b1;
      redirect_md_d     = resolve_br_metadata_fwd_i;
      redirect_taken_d  = cf & resolve_taken_i;
      redirect_ntaken_d = cf & ~resolve_taken_i;
      redirect_nonbr_d  = ~cf;
      if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 1'b1;
    end
    if (fifo_enq && (att_cnt_q != '1)) begin
      att_cnt_d = att_cnt_q + 1'b1;
    end
  end

  // State registers; reset also discards any pending redirect
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q           <= e_run;
      epoch_q           <= 1'b0;
      redirect_pc_q     <= '0;
      redirect_br_v_q   <= 1'b0;
      redirect_md_q     <= '0;
      redirect_taken_q  <= 1'b0;
      redirect_ntaken_q <= 1'b0;
      redirect_nonbr_q  <= 1'b0;
      mis_cnt_q         <= '0;
      att_cnt_q         <= '0;
    end else begin
      state_q           <= state_d;
      epoch_q           <= epoch_d;
      redirect_pc_q     <= redirect_pc_d;
      redirect_br_v_q   <= redirect_br_v_d;
      redirect_md_q     <= redirect_md_d;
      redirect_taken_q  <= redirect_taken_d;
      redirect_ntaken_q <= redirect_ntaken_d;
      redirect_nonbr_q  <= redirect_nonbr_d;
      mis_cnt_q         <= mis_cnt_d;
      att_cnt_q         <= att_cnt_d;
    end
  end

  assign redirect_v_o               = (state_q == e_wait);
  assign redirect_pc_o              = redirect_pc_q;
  assign redirect_br_v_o            = redirect_br_v_q;
  assign redirect_br_metadata_fwd_o = redirect_md_q;
  assign redirect_br_taken_o        = redirect_taken_q;
  assign redirect_br_ntaken_o       = redirect_ntaken_q;
  assign redirect_br_nonbr_o        = redirect_nonbr_q;

  assign attaboy_pc_o              = fifo_data_out.pc;
  assign attaboy_br_metadata_fwd_o = fifo_data_out.md;
  assign attaboy_taken_o           = fifo_data_out.taken;
  assign attaboy_ntaken_o          = fifo_data_out.ntaken;

  assign epoch_o          = epoch_q;
  assign mispredict_cnt_o = mis_cnt_q;
  assign attaboy_cnt_o    = att_cnt_q;

endmodule

// File: tb/tb_bp_be_fe_cmd_gen.sv
// tb/tb_bp_be_fe_cmd_gen.sv - self-checking bench for bp_be_fe_cmd_gen
module tb_bp_be_fe_cmd_gen;
  import bp_be_pkg::*;

  localparam int VA = 39;
  localparam int MW = 8;
  localparam int CW = 2;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          resolve_v_i, resolve_ready_o, resolve_epoch_i, resolve_taken_i;
  logic [VA-1:0] resolve_pc_i, resolve_npc_i, resolve_pred_npc_i;
  logic [MW-1:0] resolve_br_metadata_fwd_i;
  logic          redirect_v_o, redirect_yumi_i, redirect_br_v_o;
  logic [VA-1:0] redirect_pc_o;
  logic [MW-1:0] redirect_br_metadata_fwd_o;
  logic          redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o;
  logic          attaboy_v_o, attaboy_yumi_i, attaboy_taken_o, attaboy_ntaken_o;
  logic [VA-1:0] attaboy_pc_o;
  logic [MW-1:0] attaboy_br_metadata_fwd_o;
  logic          epoch_o;
  logic [CW-1:0] mispredict_cnt_o, attaboy_cnt_o;

  bp_be_fe_cmd_gen #(
    .bp_params_p   (e_bp_default_cfg),
    .attaboy_els_p (4),
    .cnt_width_p   (CW)
  ) dut (
    .clk_i                      (clk_i),
    .reset_n_i                  (reset_n_i),
    .resolve_v_i                (resolve_v_i),
    .resolve_ready_o            (resolve_ready_o),
    .resolve_epoch_i            (resolve_epoch_i),
    .resolve_pc_i               (resolve_pc_i),
    .resolve_npc_i              (resolve_npc_i),
    .resolve_pred_npc_i         (resolve_pred_npc_i),
    .resolve_taken_i            (resolve_taken_i),
    .resolve_br_metadata_fwd_i  (resolve_br_metadata_fwd_i),
    .redirect_v_o               (redirect_v_o),
    .redirect_yumi_i            (redirect_yumi_i),
    .redirect_pc_o              (redirect_pc_o),
    .redirect_br_v_o            (redirect_br_v_o),
    .redirect_br_metadata_fwd_o (redirect_br_metadata_fwd_o),
    .redirect_br_taken_o        (redirect_br_taken_o),
    .redirect_br_ntaken_o       (redirect_br_ntaken_o),
    .redirect_br_nonbr_o        (redirect_br_nonbr_o),
    .attaboy_v_o                (attaboy_v_o),
    .attaboy_yumi_i             (attaboy_yumi_i),
    .attaboy_pc_o               (attaboy_pc_o),
    .attaboy_br_metadata_fwd_o  (attaboy_br_metadata_fwd_o),
    .attaboy_taken_o            (attaboy_taken_o),
    .attaboy_ntaken_o           (attaboy_ntaken_o),
    .epoch_o                    (epoch_o),
    .mispredict_cnt_o           (mispredict_cnt_o),
    .attaboy_cnt_o              (attaboy_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // kind: 0 = nothing, 1 = attaboy, 2 = redirect
  typedef struct {
    logic          ep;
    logic [VA-1:0] pc;
    logic [VA-1:0] npc;
    logic [VA-1:0] pred;
    logic          taken;
    logic [MW-1:0] md;
    int            kind;
    logic          exp_taken;
    logic          exp_ntaken;
    logic          exp_nonbr;
  } vec_t;

  typedef struct {
    int            kind;
    logic [VA-1:0] pc;
    logic [MW-1:0] md;
    logic          t;
    logic          nt;
    logic          nb;
  } exp_t;

  vec_t          vecs[10];
  exp_t          sb_q[$];
  logic [VA-1:0] att_q[$];
  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic          m_epoch;
  int            m_mis, m_att;

  function automatic int sat(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a negedge; presents one resolution for one clock, returns at the next negedge
  task automatic drive(input logic ep, input logic [VA-1:0] pc, input logic [VA-1:0] npc,
                       input logic [VA-1:0] pred, input logic tk, input logic [MW-1:0] md);
    resolve_v_i = 1'b1;
    resolve_epoch_i = ep;
    resolve_pc_i = pc;
    resolve_npc_i = npc;
    resolve_pred_npc_i = pred;
    resolve_taken_i = tk;
    resolve_br_metadata_fwd_i = md;
    @(posedge clk_i);
    #1;
    resolve_v_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic pulse_redirect_yumi();
    redirect_yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    redirect_yumi_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic pulse_attaboy_yumi();
    attaboy_yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    attaboy_yumi_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    exp_t e;
    logic [VA-1:0] nv;

    // md bits: [0] is_br, [1] is_jal, [2] is_jalr, [3] src_btb, [7:4] bht_idx
    vecs[0] = '{1'b0, 39'h1000, 39'h1040, 39'h1040, 1'b1, 8'h01, 1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 39'h1000, 39'h1004, 39'h1040, 1'b0, 8'h01, 2, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 39'h1100, 39'h1200, 39'h1300, 1'b1, 8'h01, 0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 39'h1104, 39'h1140, 39'h1140, 1'b1, 8'h02, 0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 39'h1108, 39'h110c, 39'h1110, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 39'h1400, 39'h1500, 39'h1500, 1'b1, 8'h02, 1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 39'h2000, 39'h2004, 39'h3000, 1'b0, 8'h08, 2, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 39'h2004, 39'h40_0000_1000, 39'h00_0000_1000, 1'b1, 8'h34, 2, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 39'h3000, 39'h3004, 39'h3004, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 39'h3004, 39'h3008, 39'h3008, 1'b0, 8'hA1, 1, 1'b0, 1'b1, 1'b0};

    reset_n_i = 1'b0;
    resolve_v_i = 1'b0;
    resolve_epoch_i = 1'b0;
    resolve_pc_i = '0;
    resolve_npc_i = '0;
    resolve_pred_npc_i = '0;
    resolve_taken_i = 1'b0;
    resolve_br_metadata_fwd_i = '0;
    redirect_yumi_i = 1'b0;
    attaboy_yumi_i = 1'b0;
    m_epoch = 1'b0;
    m_mis = 0;
    m_att = 0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    @(negedge clk_i);

    chk("rst_redirect_v", redirect_v_o, 0);
    chk("rst_attaboy_v", attaboy_v_o, 0);
    chk("rst_epoch", epoch_o, 0);
    chk("rst_mis_cnt", mispredict_cnt_o, 0);
    chk("rst_att_cnt", attaboy_cnt_o, 0);
    chk("rst_ready", resolve_ready_o, 1);
    chk("rst_redirect_pc", redirect_pc_o, 0);
    chk("rst_redirect_br_v", redirect_br_v_o, 0);

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("v%0d_ready_pre", i), resolve_ready_o, 1);
      e = '{vecs[i].kind, vecs[i].npc, vecs[i].md, vecs[i].exp_taken,
            vecs[i].exp_ntaken, vecs[i].exp_nonbr};
      if (e.kind == 2) begin
        m_epoch = ~m_epoch;
        m_mis = sat(m_mis + 1);
      end else if (e.kind == 1) begin
        m_att = sat(m_att + 1);
      end
      sb_q.push_back(e);
      drive(vecs[i].ep, vecs[i].pc, vecs[i].npc, vecs[i].pred, vecs[i].taken, vecs[i].md);
      e = sb_q.pop_front();
      case (e.kind)
        1: begin
          chk($sformatf("v%0d_att_v", i), attaboy_v_o, 1);
          chk($sformatf("v%0d_att_pc", i), attaboy_pc_o, e.pc);
          chk($sformatf("v%0d_att_md", i), attaboy_br_metadata_fwd_o, e.md);
          chk($sformatf("v%0d_att_taken", i), attaboy_taken_o, e.t);
          chk($sformatf("v%0d_att_ntaken", i), attaboy_ntaken_o, e.nt);
          chk($sformatf("v%0d_att_no_redir", i), redirect_v_o, 0);
          pulse_attaboy_yumi();
          chk($sformatf("v%0d_att_drained", i), attaboy_v_o, 0);
        end
        2: begin
          chk($sformatf("v%0d_redir_v", i), redirect_v_o, 1);
          chk($sformatf("v%0d_redir_pc", i), redirect_pc_o, e.pc);
          chk($sformatf("v%0d_redir_br_v", i), redirect_br_v_o, 1);
          chk($sformatf("v%0d_redir_md", i), redirect_br_metadata_fwd_o, e.md);
          chk($sformatf("v%0d_redir_taken", i), redirect_br_taken_o, e.t);
          chk($sformatf("v%0d_redir_ntaken", i), redirect_br_ntaken_o, e.nt);
          chk($sformatf("v%0d_redir_nonbr", i), redirect_br_nonbr_o, e.nb);
          chk($sformatf("v%0d_redir_no_att", i), attaboy_v_o, 0);
          chk($sformatf("v%0d_redir_ready", i), resolve_ready_o, 0);
          chk($sformatf("v%0d_epoch", i), epoch_o, m_epoch);
          @(negedge clk_i);
          chk($sformatf("v%0d_redir_hold_v", i), redirect_v_o, 1);
          chk($sformatf("v%0d_redir_hold_pc", i), redirect_pc_o, e.pc);
          pulse_redirect_yumi();
          chk($sformatf("v%0d_redir_done", i), redirect_v_o, 0);
        end
        default: begin
          chk($sformatf("v%0d_none_redir", i), redirect_v_o, 0);
          chk($sformatf("v%0d_none_att", i), attaboy_v_o, 0);
        end
      endcase
      chk($sformatf("v%0d_mis_cnt", i), mispredict_cnt_o, m_mis);
      chk($sformatf("v%0d_att_cnt", i), attaboy_cnt_o, m_att);
    end

    // Reset while a redirect is pending discards it
    drive(m_epoch, 39'h5000, 39'h5004, 39'h5100, 1'b0, 8'h01);
    chk("rw_redirect_v", redirect_v_o, 1);
    reset_n_i = 1'b0;
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    @(negedge clk_i);
    m_epoch = 1'b0;
    m_mis = 0;
    m_att = 0;
    chk("rw_redirect_v_cleared", redirect_v_o, 0);
    chk("rw_epoch", epoch_o, 0);
    chk("rw_redirect_pc", redirect_pc_o, 0);
    chk("rw_mis_cnt", mispredict_cnt_o, 0);
    chk("rw_ready", resolve_ready_o, 1);

    // Backpressure: fill the 4-deep queue with no attaboy consumption
    for (int i = 0; i < 4; i++) begin
      nv = 39'h1_0000 + 39'(i * 'h40);
      resolve_v_i = 1'b1;
      resolve_epoch_i = 1'b0;
      resolve_pc_i = nv - 39'h4;
      resolve_npc_i = nv;
      resolve_pred_npc_i = nv;
      resolve_taken_i = 1'b1;
      resolve_br_metadata_fwd_i = 8'h01;
      att_q.push_back(nv);
      m_att = sat(m_att + 1);
      @(posedge clk_i);
      #1;
    end
    resolve_v_i = 1'b0;
    @(negedge clk_i);
    chk("bp_full_ready", resolve_ready_o, 0);
    chk("bp_full_att_v", attaboy_v_o, 1);
    chk("bp_att_cnt_sat", attaboy_cnt_o, m_att);
    chk("bp_head", attaboy_pc_o, att_q.pop_front());

    // Enqueue into a full queue in the same cycle as a dequeue
    nv = 39'h1_0100;
    attaboy_yumi_i = 1'b1;
    resolve_v_i = 1'b1;
    resolve_npc_i = nv;
    resolve_pred_npc_i = nv;
    #1;
    chk("bp_ready_on_deq", resolve_ready_o, 1);
    @(posedge clk_i);
    #1;
    attaboy_yumi_i = 1'b0;
    resolve_v_i = 1'b0;
    att_q.push_back(nv);
    @(negedge clk_i);
    chk("bp_still_full", resolve_ready_o, 0);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_drain%0d_v", i), attaboy_v_o, 1);
      chk($sformatf("bp_drain%0d_pc", i), attaboy_pc_o, att_q.pop_front());
      pulse_attaboy_yumi();
      chk($sformatf("bp_drain%0d_ready", i), resolve_ready_o, 1);
    end
    chk("bp_empty", attaboy_v_o, 0);

    // Five mispredicts saturate the 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      drive(m_epoch, 39'h6000, 39'h6004 + 39'(i * 4), 39'h7000, 1'b1, 8'h01);
      m_epoch = ~m_epoch;
      m_mis = sat(m_mis + 1);
      chk($sformatf("sat%0d_redir_v", i), redirect_v_o, 1);
      pulse_redirect_yumi();
      if (i == 1) chk("sat_mis_cnt_2", mispredict_cnt_o, 2);
    end
    chk("sat_mis_cnt", mispredict_cnt_o, 3);
    chk("sat_epoch", epoch_o, m_epoch);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bp_be_fe_cmd_gen.md
# bp_be_fe_cmd_gen

Backend-side producer of frontend branch-training traffic. Takes one resolved control-flow instruction per cycle from the execute stage. Compares the actual next PC with the predicted next PC and emits either a redirect, carrying a branch update and the correct PC, or an attaboy, which confirms a correct prediction, on the frontend's redirect/attaboy interface. It sits between the BE branch-resolution point and the FE PC-generation stage, and it drops wrong-path resolutions with a one-bit epoch.

## Interface
**Parameters**
- bp_params_p, e_bp_default_cfg: supplies vaddr_width_p and branch_metadata_fwd_width_p.
- attaboy_els_p, 4: attaboy queue depth (≥2).
- cnt_width_p, 16: statistics counter width.

**Ports**
- clk_i, in, 1: clock.
- reset_n_i, in, 1: reset, synchronous and active-low.
- resolve_v_i, in, 1: resolution valid.
- resolve_ready_o, out, 1: block accepts a resolution this cycle.
- resolve_epoch_i, in, 1: epoch tag carried with the instruction.
- resolve_pc_i, in, vaddr: instruction PC.
- resolve_npc_i, in, vaddr: actual next PC.
- resolve_pred_npc_i, in, vaddr: PC the frontend fetched next.
- resolve_taken_i, in, 1: branch actually taken.
- resolve_br_metadata_fwd_i, in, branch_metadata_fwd_width_p: FE metadata (is_br, is_jal, is_jalr, src_btb, …).
- redirect_v_o, out, 1: redirect command valid.
- redirect_yumi_i, in, 1: FE consumed the redirect.
- redirect_pc_o, out, vaddr: correct PC.
- redirect_br_v_o, out, 1: redirect carries a branch update.
- redirect_br_metadata_fwd_o, out, branch_metadata_fwd_width_p: metadata for the redirect.
- redirect_br_taken_o, out, 1: branch-update qualifier, taken.
- redirect_br_ntaken_o, out, 1: branch-update qualifier, not taken.
- redirect_br_nonbr_o, out, 1: branch-update qualifier, non-branch.
- attaboy_v_o, out, 1: attaboy valid.
- attaboy_yumi_i, in, 1: FE consumed the attaboy.
- attaboy_pc_o, out, vaddr: target for BTB training (resolve_npc).
- attaboy_br_metadata_fwd_o, out, branch_metadata_fwd_width_p: metadata for the attaboy.
- attaboy_taken_o, out, 1: attaboy qualifier, taken.
- attaboy_ntaken_o, out, 1: attaboy qualifier, not taken.
- epoch_o, out, 1: current epoch, for tagging new fetches.
- mispredict_cnt_o, out, cnt_width_p: saturating count of redirects issued.
- attaboy_cnt_o, out, cnt_width_p: saturating count of attaboys enqueued.

## Operation
**Acceptance**
- A resolution is accepted when resolve_v_i & resolve_ready_o.
- A resolution with resolve_epoch_i ≠ epoch_r is a wrong-path resolution. It is accepted and silently dropped.

**Classification of same-epoch resolutions**
- cf = is_br | is_jal | is_jalr.
- mispredict = resolve_npc_i ≠ resolve_pred_npc_i.
- mispredict → load the redirect register:
  - redirect_pc = resolve_npc_i; redirect_br_v = 1.
  - nonbr = ~cf.
  - taken = cf & resolve_taken_i.
  - ntaken = cf & ~resolve_taken_i.
  - Toggle epoch_r; state goes to e_wait.
- ~mispredict & cf → enqueue an attaboy with {resolve_npc_i, metadata, taken, ~taken}.
- ~mispredict & ~cf → no action.

**State machine**
- e_run:
  - resolve_ready_o = attaboy queue not full.
- e_wait:
  - redirect_v_o = 1 and resolve_ready_o = 0.
  - attaboy_v_o is forced 0.
  - redirect_yumi_i → e_run.

**Attaboy queue**
- Older attaboys already queued are retained and drained after the redirect is consumed.
- attaboy_v_o = queue not empty & state == e_run.
- Enqueue and dequeue in the same cycle are legal when full, since dequeue frees the slot first.

**Counters**
- Increment on redirect load and on attaboy enqueue respectively.
- Saturate at all-ones and never wrap.

**Widths**
- PCs are compared at full vaddr width with no sign-extension.
- Metadata passes through unmodified.

## Timing
- Reset (reset_n_i = 0 at a clock edge):
  - State = e_run, epoch_r = 0, queue empty, counters = 0.
  - All *_v_o = 0; redirect data registers = 0.
- Reset mid-e_wait discards the pending redirect.
- Latency: accepted resolution → redirect_v_o or attaboy_v_o asserted the next cycle (registered outputs); no combinational path from resolve_* to outputs.
- epoch_o changes the cycle after the mispredicting resolution is accepted.
- Once asserted, redirect outputs and attaboy outputs hold stable until the matching yumi.
- Simultaneous enqueue and dequeue on an empty queue:
  - The enqueued entry does not appear until the next cycle.
  - attaboy_v_o deasserts for one cycle only if the queue became empty.

## Structure
- bp_be_fe_cmd_state_e {e_run, e_wait} and the attaboy entry struct belong in bp_be_pkg.
- The metadata struct comes from the existing bp_fe_branch_metadata_fwd_s declare macro.
- The attaboy queue is a bsg_fifo_1r1w_small sub-module, the one natural sub-module. Its reset is driven by ~reset_n_i.
- The redirect register, FSM, epoch and counters are local logic.

## Test plan
- Correct branch: is_br, taken, pc=0x1000, npc=pred=0x1040 → attaboy next cycle with pc_o=0x1040, taken_o=1; attaboy_cnt=1.
- Mispredict: is_br, not taken, npc=0x1004, pred=0x1040, epoch 0:
  - redirect_v_o=1, pc_o=0x1004, ntaken_o=1, epoch_o=1.
  - resolve_ready_o=0 until yumi.
- Wrong-path drop: after the mispredict, send 3 resolutions tagged epoch 0 → no outputs, counters unchanged. Then an epoch-1 correct jal → one attaboy.
- BTB false hit: non-cf, src_btb=1, npc=0x2004, pred=0x3000 → redirect with nonbr_o=1, taken_o=ntaken_o=0.
- Backpressure: attaboy_yumi_i=0 with 4 correct branches → queue full, resolve_ready_o=0. One yumi → ready returns, and entries arrive in FIFO order.
- Reset and saturation:
  - reset_n_i=0 during e_wait → next cycle redirect_v_o=0, epoch_o=0.
  - With cnt_width_p=2, 5 mispredicts → mispredict_cnt_o=3.
